mfp_ahb_lite_srec_dumper: RTL and testbench

Memory read-back engine, the opposite direction of the UART S-record loader. On a start request it reads a range of 32-bit words as an AHB-Lite master and emits each word as one Motorola S3 record, as a stream of ASCII characters for a UART transmitter. It finishes with an S7 terminator record. It sits beside the loader and is muxed onto the AHB-Lite matrix master port while busy.

---
 rtl/mfp_ahb_lite_srec_dumper_pkg.sv | 45 ++++
 rtl/mfp_srec_record_serializer.sv | 86 ++++++++
 rtl/mfp_ahb_lite_srec_dumper.sv | 168 ++++++++++++++++
 tb/tb_mfp_ahb_lite_srec_dumper.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_lite_srec_dumper_pkg.sv
// Shared constants and types for the S-record dumper: record characters,
// S-record count/checksum bytes, AHB-Lite encodings, the dumper FSM states
// and small helpers.
package mfp_ahb_lite_srec_dumper_pkg;

  // Record characters and line terminators
  localparam logic [7:0] SREC_CHAR_S   = 8'h53;
  localparam logic [7:0] SREC_CHAR_3   = 8'h33;
  localparam logic [7:0] SREC_CHAR_7   = 8'h37;
  localparam logic [7:0] SREC_CR       = 8'h0D;
  localparam logic [7:0] SREC_LF       = 8'h0A;

  // Count bytes: S3 = 4 address + 4 data + 1 checksum, S7 = 4 address + 1 checksum
  localparam logic [7:0] SREC_S3_COUNT = 8'h09;
  localparam logic [7:0] SREC_S7_COUNT = 8'h05;
  // S7 terminator always carries address 0, so its checksum is fixed
  localparam logic [7:0] SREC_S7_CSUM  = 8'hFA;

  // AHB-Lite encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_EMIT = 3'd3,
    ST_TERM = 3'd4,
    ST_FIN  = 3'd5
  } dump_state_e;

  // Uppercase ASCII hex digit
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Reverse byte order of a 32-bit word
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mfp_srec_record_serializer.sv
// Serialises one S3 or S7 record into ASCII characters over a valid/ready
// handshake. A transfer happens on o_char_valid && i_char_ready; o_char_data
// is held stable while valid is high and ready is low. o_done pulses for one
// cycle after the final LF has been accepted.
module mfp_srec_record_serializer
  import mfp_ahb_lite_srec_dumper_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_is_s7,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [7:0]  o_char_data,
  output logic        o_char_valid,
  input  logic        i_char_ready,
  output logic        o_done
);

  logic        r_valid;
  logic        r_done;
  logic        r_is_s7;
  logic [4:0]  r_idx;
  // Hex payload {count, address, [data,] checksum}, left-aligned; shifted
  // one nibble per emitted digit so the next digit is always [79:76].
  logic [79:0] r_payload;

  logic [7:0]  w_csum;
  logic [4:0]  w_ndig;
  logic [4:0]  w_dig_end;
  logic [4:0]  w_last_idx;
  logic [7:0]  w_char;

  // S3 checksum: ones' complement of the low byte of the byte sum
  always_comb begin
    w_csum = ~(SREC_S3_COUNT + i_addr[31:24] + i_addr[23:16] + i_addr[15:8] + i_addr[7:0]
               + i_data[31:24] + i_data[23:16] + i_data[15:8] + i_data[7:0]);
  end

  // Character selection: 'S', type, hex digits, CR, LF
  always_comb begin
    w_ndig     = r_is_s7 ? 5'd12 : 5'd20;
    w_dig_end  = w_ndig + 5'd2;
    w_last_idx = w_ndig + 5'd3;
    w_char     = SREC_LF;
    if (r_idx == 5'd0)           w_char = SREC_CHAR_S;
    else if (r_idx == 5'd1)      w_char = r_is_s7 ? SREC_CHAR_7 : SREC_CHAR_3;
    else if (r_idx < w_dig_end)  w_char = hex_char(r_payload[79:76]);
    else if (r_idx == w_dig_end) w_char = SREC_CR;
  end

  assign o_char_data  = r_valid ? w_char : 8'h00;
  assign o_char_valid = r_valid;
  assign o_done       = r_done;

  // Record sequencer: load on start, advance on each accepted character
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_is_s7   <= 1'b0;
      r_idx     <= 5'd0;
      r_payload <= 80'h0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_valid   <= 1'b1;
        r_is_s7   <= i_is_s7;
        r_idx     <= 5'd0;
        r_payload <= i_is_s7 ? {SREC_S7_COUNT, i_addr, SREC_S7_CSUM, 32'h0}
                             : {SREC_S3_COUNT, i_addr, i_data, w_csum};
      end else if (r_valid && i_char_ready) begin
        if (r_idx == w_last_idx) begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx + 5'd1;
          if (r_idx >= 5'd2 && r_idx < w_dig_end) begin
            r_payload <= {r_payload[75:0], 4'h0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/mfp_ahb_lite_srec_dumper.sv
// Memory read-back engine: reads word_count words over AHB-Lite starting at
// start_address and emits each as an S3 record, then an S7 terminator. An
// error response aborts the dump without the terminator.
module mfp_ahb_lite_srec_dumper
  import mfp_ahb_lite_srec_dumper_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   big_endian,
  input  logic                   start,
  input  logic [31:0]            start_address,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic [31:0]            HADDR,
  output logic [2:0]             HBURST,
  output logic                   HMASTLOCK,
  output logic [3:0]             HPROT,
  output logic [2:0]             HSIZE,
  output logic [1:0]             HTRANS,
  output logic [31:0]            HWDATA,
  output logic                   HWRITE,
  input  logic [31:0]            HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [7:0]             char_data,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  dump_state_e            r_state;
  logic [31:0]            r_addr;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic                   r_be;
  logic [1:0]             r_htrans;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic                   w_ser_start;
  logic                   w_ser_is_s7;
  logic [31:0]            w_ser_addr;
  logic [31:0]            w_rdata_ordered;
  logic                   w_ser_done;

  assign HADDR     = r_addr;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_DATA;
  assign HSIZE     = HSIZE_WORD;
  assign HTRANS    = r_htrans;
  assign HWDATA    = 32'h0;
  assign HWRITE    = 1'b0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

  // Put read data in address order: lowest-address byte at [31:24]
  assign w_rdata_ordered = r_be ? HRDATA : byte_swap(HRDATA);
  assign w_ser_addr      = w_ser_is_s7 ? 32'h0 : r_addr;

  // Kick the serializer on the cycle each record's contents become known
  always_comb begin
    w_ser_start = 1'b0;
    w_ser_is_s7 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ser_start = start && (word_count == '0);
        w_ser_is_s7 = 1'b1;
      end
      ST_DATA: w_ser_start = HREADY && !HRESP;
      ST_EMIT: begin
        w_ser_start = w_ser_done && (r_remaining == COUNT_WIDTH'(1));
        w_ser_is_s7 = 1'b1;
      end
      default: ;
    endcase
  end

  mfp_srec_record_serializer u_serializer (
    .i_clk        (HCLK),
    .i_rst_n      (HRESETn),
    .i_start      (w_ser_start),
    .i_is_s7      (w_ser_is_s7),
    .i_addr       (w_ser_addr),
    .i_data       (w_rdata_ordered),
    .o_char_data  (char_data),
    .o_char_valid (char_valid),
    .i_char_ready (char_ready),
    .o_done       (w_ser_done)
  );

  // AHB read FSM with registered bus and status outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_addr      <= 32'h0;
      r_remaining <= '0;
      r_be        <= 1'b0;
      r_htrans    <= HTRANS_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= {start_address[31:2], 2'b00};
            r_remaining <= word_count;
            r_be        <= big_endian;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            if (word_count == '0) begin
              r_state <= ST_TERM;
            end else begin
              r_state  <= ST_ADDR;
              r_htrans <= HTRANS_NONSEQ;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            r_htrans <= HTRANS_IDLE;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            if (HRESP) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_state <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (w_ser_done) begin
            r_addr      <= r_addr + 32'd4;
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
            if (r_remaining == COUNT_WIDTH'(1)) begin
              r_state <= ST_TERM;
            end else begin
              r_state  <= ST_ADDR;
              r_htrans <= HTRANS_NONSEQ;
            end
          end
        end
        ST_TERM: begin
          if (w_ser_done) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_lite_srec_dumper.sv
// Directed bench for the S-record dumper: an AHB slave and character sink
// driven on the falling edge, expected characters and read addresses held
// in scoreboard queues.
module tb_mfp_ahb_lite_srec_dumper;

  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          big_endian = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   start_address = 32'h0;
  logic [CW-1:0] word_count = '0;
  logic [31:0]   HADDR;
  logic [2:0]    HBURST;
  logic          HMASTLOCK;
  logic [3:0]    HPROT;
  logic [2:0]    HSIZE;
  logic [1:0]    HTRANS;
  logic [31:0]   HWDATA;
  logic          HWRITE;
  logic [31:0]   HRDATA = 32'h0;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;
  logic [7:0]    char_data;
  logic          char_valid;
  logic          char_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          error;

  always #5 HCLK = ~HCLK;

  mfp_ahb_lite_srec_dumper #(.COUNT_WIDTH(CW)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .big_endian    (big_endian),
    .start         (start),
    .start_address (start_address),
    .word_count    (word_count),
    .HADDR         (HADDR),
    .HBURST        (HBURST),
    .HMASTLOCK     (HMASTLOCK),
    .HPROT         (HPROT),
    .HSIZE         (HSIZE),
    .HTRANS        (HTRANS),
    .HWDATA        (HWDATA),
    .HWRITE        (HWRITE),
    .HRDATA        (HRDATA),
    .HREADY        (HREADY),
    .HRESP         (HRESP),
    .char_data     (char_data),
    .char_valid    (char_valid),
    .char_ready    (char_ready),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  // ---------------- scoreboard state ----------------
  int          n_total = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];
  bit          mon_en = 1'b0;
  bit          ws_en = 1'b0;
  bit          stall_en = 1'b0;
  int          err_idx = -1;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  logic        busy_at_done = 1'b0;
  logic        err_at_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h12345678;
    return a ^ 32'h5A5A0000;
  endfunction

  task automatic push_rec(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- AHB slave + char sink + monitor ----------------
  initial begin : bus_model
    bit          dp_active;
    bit          next_dp;
    logic [31:0] dp_addr;
    int          wait_left;
    int          dp_num;
    bit          prev_pend;
    logic [7:0]  prev_data;
    dp_active = 1'b0; dp_addr = 32'h0; wait_left = 0; dp_num = 0;
    prev_pend = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge HCLK);
      char_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (mon_en && prev_pend) begin
        check_eq("hold_valid", {31'h0, char_valid}, 32'd1);
        check_eq("hold_data", {24'h0, char_data}, {24'h0, prev_data});
      end
      prev_pend = char_valid && !char_ready;
      prev_data = char_data;
      if (mon_en && char_valid && char_ready) begin
        if (exp_q.size() == 0) check_eq("extra_char", {24'h0, char_data}, 32'hFFFF_FFFF);
        else check_eq("char", {24'h0, char_data}, {24'h0, exp_q.pop_front()});
      end
      if (mon_en && done) begin
        done_cnt++;
        busy_at_done = busy;
        err_at_done  = error;
      end
      HRESP = 1'b0;
      if (dp_active) begin
        HREADY = (wait_left == 0);
        if (HREADY) begin
          HRDATA = mem_word(dp_addr);
          HRESP  = (dp_num == err_idx);
        end else begin
          HRDATA = $urandom;
        end
        if (wait_left > 0) wait_left--;
      end else begin
        HREADY = ws_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      next_dp = dp_active && !HREADY;
      if (HTRANS == 2'b10 && HREADY) begin
        if (mon_en) begin
          rd_cnt++;
          if (exp_addr_q.size() == 0) check_eq("extra_read", HADDR, 32'hFFFF_FFFF);
          else check_eq("rd_addr", HADDR, exp_addr_q.pop_front());
        end
        next_dp   = 1'b1;
        dp_addr   = HADDR;
        dp_num    = rd_cnt;
        wait_left = ws_en ? $urandom_range(0, 3) : 0;
      end
      dp_active = next_dp;
    end
  end

  // ---------------- driver task ----------------
  task automatic run_test(input logic [31:0] a, input logic [CW-1:0] n, input logic be,
                          input int exp_reads, input logic exp_err, input bit poke);
    int d0;
    bit seen;
    rd_cnt = 0;
    d0 = done_cnt;
    @(negedge HCLK);
    start_address = a; word_count = n; big_endian = be; start = 1'b1;
    @(negedge HCLK);
    start = 1'b0; start_address = $urandom; word_count = CW'($urandom); big_endian = ~be;
    check_eq("busy_after_start", {31'h0, busy}, 32'd1);
    check_eq("error_cleared", {31'h0, error}, 32'd0);
    if (poke) begin
      repeat (20) @(negedge HCLK);
      start = 1'b1; start_address = 32'h0000_0400; word_count = CW'(3);
      @(negedge HCLK);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge HCLK);
      if (done_cnt != d0) seen = 1'b1;
    end
    check_eq("done_timeout", {31'h0, seen}, 32'd1);
    repeat (4) @(posedge HCLK);
    #1;
    check_eq("done_pulses", done_cnt - d0, 32'd1);
    check_eq("busy_at_done", {31'h0, busy_at_done}, 32'd0);
    check_eq("error_at_done", {31'h0, err_at_done}, {31'h0, exp_err});
    check_eq("error_after", {31'h0, error}, {31'h0, exp_err});
    check_eq("busy_idle", {31'h0, busy}, 32'd0);
    check_eq("reads", rd_cnt, exp_reads);
    check_eq("chars_left", exp_q.size(), 32'd0);
    check_eq("addr_left", exp_addr_q.size(), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit seen;
    repeat (3) @(posedge HCLK);
    #1;
    check_eq("rst_htrans", {30'h0, HTRANS}, 32'd0);
    check_eq("rst_haddr", HADDR, 32'd0);
    check_eq("rst_hsize", {29'h0, HSIZE}, 32'd2);
    check_eq("rst_hprot", {28'h0, HPROT}, 32'd3);
    check_eq("rst_hburst", {29'h0, HBURST}, 32'd0);
    check_eq("rst_hwrite", {31'h0, HWRITE}, 32'd0);
    check_eq("rst_hwdata", HWDATA, 32'd0);
    check_eq("rst_hmastlock", {31'h0, HMASTLOCK}, 32'd0);
    check_eq("rst_char_valid", {31'h0, char_valid}, 32'd0);
    check_eq("rst_char_data", {24'h0, char_data}, 32'd0);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_done", {31'h0, done}, 32'd0);
    check_eq("rst_error", {31'h0, error}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    mon_en = 1'b1;

    // Big-endian single word
    push_rec("S3090000000012345678E2"); push_rec("S70500000000FA");
    exp_addr_q.push_back(32'h0);
    run_test(32'h0, CW'(1), 1'b1, 1, 1'b0, 1'b0);

    // Little-endian single word
    push_rec("S3090000000078563412E2"); push_rec("S70500000000FA");
    exp_addr_q.push_back(32'h0);
    run_test(32'h0, CW'(1), 1'b0, 1, 1'b0, 1'b0);

    // Unaligned start, address wrap
    push_rec("S309FFFFFFFCA5A5FFFCB8"); push_rec("S3090000000012345678E2");
    push_rec("S70500000000FA");
    exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
    run_test(32'hFFFF_FFFD, CW'(2), 1'b1, 2, 1'b0, 1'b0);

    // Zero words: terminator only
    push_rec("S70500000000FA");
    run_test(32'h0000_1234, CW'(0), 1'b1, 0, 1'b0, 1'b0);

    // Error on second of three reads
    err_idx = 2;
    push_rec("S309000001005A5A010040");
    exp_addr_q.push_back(32'h100); exp_addr_q.push_back(32'h104);
    run_test(32'h0000_0100, CW'(3), 1'b1, 2, 1'b1, 1'b0);
    err_idx = -1;

    // Stalls, wait states, ignored start while busy
    stall_en = 1'b1; ws_en = 1'b1;
    push_rec("S309FFFFFFFCA5A5FFFCB8"); push_rec("S3090000000012345678E2");
    push_rec("S70500000000FA");
    exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
    run_test(32'hFFFF_FFFD, CW'(2), 1'b1, 2, 1'b0, 1'b1);
    stall_en = 1'b0; ws_en = 1'b0;

    // Async reset during address phase and during a record
    mon_en = 1'b0;
    @(negedge HCLK);
    start_address = 32'h0; word_count = CW'(1); big_endian = 1'b1; start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    check_eq("arst_pre_htrans", {30'h0, HTRANS}, 32'd2);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("arst_htrans", {30'h0, HTRANS}, 32'd0);
    check_eq("arst_busy", {31'h0, busy}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge HCLK);
      if (char_valid) seen = 1'b1;
    end
    check_eq("arst_char_wait", {31'h0, seen}, 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("arst_char_valid", {31'h0, char_valid}, 32'd0);
    check_eq("arst_char_busy", {31'h0, busy}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    mon_en = 1'b1;

    // Clean dump after reset
    push_rec("S3090000000012345678E2"); push_rec("S70500000000FA");
    exp_addr_q.push_back(32'h0);
    run_test(32'h0, CW'(1), 1'b1, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
